// File: rtl/saat_kontrol.sv
// Run/stop and time-set controller for the HH:MM:SS:cc clock: 100 Hz tick,
// debounced buttons, STOP/RUN/SET_HOUR/SET_MIN FSM, BCD edit registers, blink mask.

module saat_kontrol_btn (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  input  logic smp_i,
  output logic ev_o
);
  logic sync1_q, sync2_q, smp_q, ev_q;

  // Level is only looked at on the tick, which is what debounces it.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      smp_q   <= 1'b0;
      ev_q    <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (smp_i) begin
        smp_q <= sync2_q;
        ev_q  <= sync2_q & ~smp_q;
      end else begin
        ev_q  <= 1'b0;
      end
    end
  end

  assign ev_o = ev_q;
endmodule

module saat_kontrol #(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 100,
  parameter int BLINK_TICKS = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic [1:0] cur_saat1,
  input  logic [3:0] cur_saat0,
  input  logic [2:0] cur_dakika1,
  input  logic [3:0] cur_dakika0,
  output logic       tick_en,
  output logic       load,
  output logic [1:0] set_saat1,
  output logic [3:0] set_saat0,
  output logic [2:0] set_dakika1,
  output logic [3:0] set_dakika0,
  output logic [3:0] blank_mask,
  output logic       running,
  output logic [1:0] mode
);
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int PW      = $clog2(DIV);
  localparam int BW      = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int NUM_BTN = 3;
  localparam logic [PW-1:0] PTERM = PW'(DIV - 1);
  localparam logic [BW-1:0] BTERM = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOUR = 2'd2,
    ST_MIN  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          ph_q, ph_d;
  logic [1:0]    h1_q, h1_d;
  logic [3:0]    h0_q, h0_d;
  logic [2:0]    m1_q, m1_d;
  logic [3:0]    m0_q, m0_d;
  logic          tick_q, tick_d;
  logic          load_q, load_d;
  logic          run_q, run_d;
  logic [3:0]    mask_q, mask_d;
  logic          wrap, blk_clr;
  logic          ev_start, ev_mode, ev_inc;
  logic [NUM_BTN-1:0] btn_raw, btn_ev;

  assign wrap    = (presc_q == PTERM);
  assign btn_raw = {inc_btn, mode_btn, start};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    saat_kontrol_btn u_btn (
      .clk   (clk),
      .reset (reset),
      .btn_i (btn_raw[g]),
      .smp_i (wrap),
      .ev_o  (btn_ev[g])
    );
  end

  // mode beats start/inc when they land in the same sample
  assign ev_mode  = btn_ev[1];
  assign ev_start = btn_ev[0] & ~btn_ev[1];
  assign ev_inc   = btn_ev[2] & ~btn_ev[1];

  always_comb begin
    state_d = state_q;
    h1_d    = h1_q;
    h0_d    = h0_q;
    m1_d    = m1_q;
    m0_d    = m0_q;
    load_d  = 1'b0;
    blk_clr = 1'b0;
    case (state_q)
      ST_STOP, ST_RUN: begin
        if (ev_mode) begin
          state_d = ST_HOUR;
          h1_d    = cur_saat1;
          h0_d    = cur_saat0;
          m1_d    = cur_dakika1;
          m0_d    = cur_dakika0;
          blk_clr = 1'b1;
        end else if (ev_start) begin
          state_d = (state_q == ST_STOP) ? ST_RUN : ST_STOP;
        end
      end
      ST_HOUR: begin
        if (ev_mode) begin
          state_d = ST_MIN;
          blk_clr = 1'b1;
        end else if (ev_inc) begin
          blk_clr = 1'b1;
          if ((h1_q > 2'd2) || (h1_q == 2'd2 && h0_q >= 4'd3)) begin
            h1_d = 2'd0;
            h0_d = 4'd0;
          end else if (h0_q >= 4'd9) begin
            h1_d = h1_q + 2'd1;
            h0_d = 4'd0;
          end else begin
            h0_d = h0_q + 4'd1;
          end
        end
      end
      ST_MIN: begin
        if (ev_mode) begin
          state_d = ST_RUN;
          load_d  = 1'b1;
        end else if (ev_inc) begin
          blk_clr = 1'b1;
          if ((m1_q > 3'd5) || (m1_q == 3'd5 && m0_q >= 4'd9)) begin
            m1_d = 3'd0;
            m0_d = 4'd0;
          end else if (m0_q >= 4'd9) begin
            m1_d = m1_q + 3'd1;
            m0_d = 4'd0;
          end else begin
            m0_d = m0_q + 4'd1;
          end
        end
      end
      default: state_d = ST_STOP;
    endcase

    // Prescaler restarts with the load so the first tick lands a full period later.
    if (load_d || wrap) presc_d = '0;
    else                presc_d = presc_q + PW'(1);

    blk_d = blk_q;
    ph_d  = ph_q;
    if (blk_clr) begin
      blk_d = '0;
      ph_d  = 1'b0;
    end else if (wrap) begin
      if (blk_q == BTERM) begin
        blk_d = '0;
        ph_d  = ~ph_q;
      end else begin
        blk_d = blk_q + BW'(1);
      end
    end

    tick_d = wrap && (state_d == ST_RUN);
    run_d  = (state_d == ST_RUN);
    case (state_d)
      ST_HOUR: mask_d = {ph_d, ph_d, 2'b00};
      ST_MIN:  mask_d = {2'b00, ph_d, ph_d};
      default: mask_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STOP;
      presc_q <= '0;
      blk_q   <= '0;
      ph_q    <= 1'b0;
      h1_q    <= '0;
      h0_q    <= '0;
      m1_q    <= '0;
      m0_q    <= '0;
      tick_q  <= 1'b0;
      load_q  <= 1'b0;
      run_q   <= 1'b0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      blk_q   <= blk_d;
      ph_q    <= ph_d;
      h1_q    <= h1_d;
      h0_q    <= h0_d;
      m1_q    <= m1_d;
      m0_q    <= m0_d;
      tick_q  <= tick_d;
      load_q  <= load_d;
      run_q   <= run_d;
      mask_q  <= mask_d;
    end
  end

  assign tick_en     = tick_q;
  assign load        = load_q;
  assign set_saat1   = h1_q;
  assign set_saat0   = h0_q;
  assign set_dakika1 = m1_q;
  assign set_dakika0 = m0_q;
  assign blank_mask  = mask_q;
  assign running     = run_q;
  assign mode        = state_q;
endmodule

// File: doc/saat_kontrol.md
Name: saat_kontrol

Overview:
Run/stop and time-set controller for the 7-segment HH:MM:SS:cc clock counter. It generates the 100 Hz count-enable tick and debounces the start, mode and inc buttons. It runs the RUN/STOP/SET_HOUR/SET_MIN state machine, keeps the BCD edit registers, and pulses a load to the counter datapath. It also drives a blink mask so the display decoder can blank the digit pair being edited.

Parameters:
CLK_HZ, 50000000, input clock frequency.
TICK_HZ, 100, count-enable rate (centisecond); CLK_HZ/TICK_HZ must be an integer ≥ 2.
BLINK_TICKS, 25, ticks per blink half-period.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  raw run/stop button, asynchronous
mode_btn  in  1  raw mode button, asynchronous
inc_btn  in  1  raw increment button, asynchronous
cur_saat1  in  2  current hours tens (BCD) from counter
cur_saat0  in  4  current hours units
cur_dakika1  in  3  current minutes tens
cur_dakika0  in  4  current minutes units
tick_en  out  1  one-cycle count enable for the counter
load  out  1  one-cycle load strobe; the counter loads set_* and clears seconds and centiseconds
set_saat1  out  2  edit hours tens
set_saat0  out  4  edit hours units
set_dakika1  out  3  edit minutes tens
set_dakika0  out  4  edit minutes units
blank_mask  out  4  bit3 = saat1, bit2 = saat0, bit1 = dakika1, bit0 = dakika0; 1 = blank digit
running  out  1  1 in RUN
mode  out  2  state: STOP=0, RUN=1, SET_HOUR=2, SET_MIN=3

Behaviour:
- Single clock domain. reset is synchronous and active-high. All outputs are registered.
- Reset values: tick_en=0, load=0, set_*=0, blank_mask=0, running=0, mode=STOP. Prescaler and blink counter are cleared.
- Prescaler:
  - Free-running, counts 0..CLK_HZ/TICK_HZ-1.
  - wrap = the cycle in which the count equals the terminal value.
  - The count restarts at 0 in the cycle load is asserted.
- tick_en = 1 for exactly one cycle at each wrap, and only while in RUN. It is never asserted in any other state.
- Button path:
  - Each button passes through a 2-flop synchronizer.
  - The synchronized level is sampled only at wrap, which gives a 10 ms debounce.
  - A press event = (sample=1, previous sample=0). An event is valid for one cycle, acted on at the following clock edge.
  - A held button gives one event. A pulse that never overlaps a wrap sample is ignored.
- Simultaneous events in the same sample: mode_btn wins over start and inc; the others are dropped.
- FSM transitions:
  - STOP: start → RUN. mode → SET_HOUR, capturing cur_* into set_*.
  - RUN: start → STOP. mode → SET_HOUR, capturing cur_*; counting halts on entry.
  - SET_HOUR:
    - inc → hours +1 in BCD: units 9→0 with tens +1; 23→00.
    - mode → SET_MIN.
    - start is ignored.
  - SET_MIN:
    - inc → minutes +1 in BCD: 59→00, with no carry into hours.
    - mode → RUN, with load=1 in the first cycle of RUN for exactly one cycle.
    - start is ignored.
- set_* hold their value outside SET states and are stable while load=1.
- Captured values are assumed legal BCD. If an out-of-range value is captured (hours > 23, minutes > 59), the next inc wraps it to 00.
- Blink:
  - The blink counter counts wraps 0..BLINK_TICKS-1 and toggles the phase at the terminal count.
  - The phase and counter clear on entry to SET_HOUR or SET_MIN, and on every accepted inc, so the digit is visible immediately.
  - blank_mask = {phase, phase, 0, 0} in SET_HOUR; {0, 0, phase, phase} in SET_MIN; 0 otherwise.
- Reset in any state: next cycle is STOP with all outputs at reset values. An edit in progress is discarded and no load is issued.

Test Plan:
(Bench parameters: CLK_HZ=1000, TICK_HZ=100, BLINK_TICKS=5, giving a 10-clk tick period.)
1. Run/stop:
   - Reset, then hold start for 30 clk → running=1, mode=1.
   - tick_en pulses exactly 1 cycle wide every 10 clk.
   - A second start press → mode=0, no further tick_en.
2. Full edit with wrap:
   - Setup: cur=23:58, in STOP.
   - mode → mode=2, set=23:58. inc → 00:58.
   - mode → mode=3. inc ×2 → 00:59, then 00:00.
   - mode → load=1 for one cycle with set=00:00, mode=1, first tick_en 10 clk after load.
3. Debounce:
   - A 3-clk inc pulse placed between wrap samples in SET_HOUR → no change.
   - inc held 50 clk → exactly one increment.
4. Blink:
   - In SET_HOUR, blank_mask alternates 0000 and 1100 every 50 clk.
   - An inc press forces 0000 and restarts the 50-clk phase.
   - In SET_MIN, the pattern is 0011.
5. Priority:
   - mode and inc rising in the same sample while in SET_HOUR → mode=3, hours unchanged.
   - start and mode together in RUN → mode=2.
6. Reset mid-edit:
   - reset for 1 clk while in SET_MIN at set=12:34 → next cycle mode=0, set=00:00, blank_mask=0.
   - load is never asserted.
